// File: rtl/cic_comp_fir_decim.sv
// rtl/cic_comp_fir_decim.sv - decimate-by-2 compensating FIR behind the CIC decimator.
// One time-shared MAC walks a circular sample RAM per output; a small FSM sequences clear/idle/MAC/round.
module cic_comp_fir_decim #(
    parameter int IN_WIDTH   = 18,
    parameter int OUT_WIDTH  = 18,
    parameter int COEF_WIDTH = 18,
    parameter int NTAPS      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_strobe,
    input  logic [IN_WIDTH-1:0]      in_data,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]    coef_data,
    output logic                     out_strobe,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     ready,
    output logic                     busy,
    output logic                     overrun
);
    localparam int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(NTAPS);
    localparam int PROD_WIDTH = IN_WIDTH + COEF_WIDTH;
    localparam int AW         = $clog2(NTAPS);
    localparam int CW         = $clog2(NTAPS + 3);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CLR_LAST = CW'(NTAPS - 1);
    localparam logic [CW-1:0] TAP_END  = CW'(NTAPS);
    localparam logic [CW-1:0] MAC_LAST = CW'(NTAPS + 2);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(2 ** (COEF_WIDTH - 2));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_ROUND} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0] wptr_q, wptr_d, base_q, base_d;
    logic phase_q, phase_d, busy_q, busy_d, ready_q, ready_d;
    logic overrun_q, overrun_d, out_strobe_q, out_strobe_d;
    logic rd_v_q, rd_v_d, prod_v_q, prod_v_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, round_sum, round_shr;
    logic signed [PROD_WIDTH-1:0] prod_q, prod_d;

    // The ring is 2*NTAPS deep so samples arriving mid-MAC never land on taps still to be read.
    // Only the upper half is cleared: the lower half is always written before the window reaches it.
    logic [IN_WIDTH-1:0]   sample_mem [2*NTAPS];
    logic [COEF_WIDTH-1:0] coef_mem   [NTAPS];
    logic signed [IN_WIDTH-1:0]   x_rd_q;
    logic signed [COEF_WIDTH-1:0] c_rd_q;
    logic                 mem_we;
    logic [AW:0]          mem_waddr, rd_addr;
    logic [IN_WIDTH-1:0]  mem_wdata;
    logic                 accept;

    assign accept  = in_strobe && (state_q != S_CLEAR);
    assign rd_addr = base_q - (AW + 1)'(cnt_q[AW-1:0]);

    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            sample_mem[mem_waddr] <= mem_wdata;
        end
        x_rd_q <= sample_mem[rd_addr];
    end

    always_ff @(posedge clock) begin
        if (coef_we) begin
            coef_mem[coef_addr] <= coef_data;
        end
        c_rd_q <= coef_mem[cnt_q[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            cnt_q        <= '0;
            wptr_q       <= '0;
            base_q       <= '0;
            phase_q      <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            overrun_q    <= 1'b0;
            out_strobe_q <= 1'b0;
            out_data_q   <= '0;
            rd_v_q       <= 1'b0;
            prod_v_q     <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wptr_q       <= wptr_d;
            base_q       <= base_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            overrun_q    <= overrun_d;
            out_strobe_q <= out_strobe_d;
            out_data_q   <= out_data_d;
            rd_v_q       <= rd_v_d;
            prod_v_q     <= prod_v_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (cnt_q == CLR_LAST) state_d = S_IDLE;
            S_IDLE:  if (accept && phase_q) state_d = S_MAC;
            S_MAC:   if (cnt_q == MAC_LAST) state_d = S_ROUND;
            S_ROUND: state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        wptr_d       = wptr_q;
        base_d       = base_q;
        phase_d      = phase_q;
        busy_d       = busy_q;
        ready_d      = ready_q;
        overrun_d    = overrun_q;
        out_strobe_d = 1'b0;
        out_data_d   = out_data_q;
        mem_we       = 1'b0;
        mem_waddr    = wptr_q;
        mem_wdata    = in_data;
        rd_v_d       = (state_q == S_MAC) && (cnt_q < TAP_END);
        prod_v_d     = rd_v_q;
        prod_d       = PROD_WIDTH'(x_rd_q) * PROD_WIDTH'(c_rd_q);
        acc_d        = prod_v_q ? acc_q + ACC_WIDTH'(prod_q) : acc_q;
        round_sum    = acc_q + RND_HALF;
        round_shr    = round_sum >>> (COEF_WIDTH - 1);

        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {1'b1, cnt_q[AW-1:0]};
                mem_wdata = '0;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CLR_LAST) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end
            end
            S_MAC: cnt_d = cnt_q + CNT_ONE;
            S_ROUND: begin
                out_strobe_d = 1'b1;
                busy_d       = 1'b0;
                if (round_shr > SAT_MAX) begin
                    out_data_d = SAT_MAX[OUT_WIDTH-1:0];
                end else if (round_shr < SAT_MIN) begin
                    out_data_d = SAT_MIN[OUT_WIDTH-1:0];
                end else begin
                    out_data_d = round_shr[OUT_WIDTH-1:0];
                end
            end
            default: ;
        endcase

        if (accept) begin
            mem_we    = 1'b1;
            mem_waddr = wptr_q;
            mem_wdata = in_data;
            wptr_d    = wptr_q + PTR_ONE;
            phase_d   = !phase_q;
            if (phase_q) begin
                if (state_q == S_IDLE) begin
                    base_d = wptr_q;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    acc_d  = '0;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    assign out_strobe = out_strobe_q;
    assign out_data   = out_data_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir_decim.sv
// tb/tb_cic_comp_fir_decim.sv - directed bench with a sample-history golden model for cic_comp_fir_decim.
module tb_cic_comp_fir_decim;
    localparam int NT  = 32;
    localparam int W   = 18;
    localparam int LAT = NT + 4;

    logic clock = 1'b0;
    logic reset, in_strobe, coef_we;
    logic [W-1:0] in_data, coef_data, out_data;
    logic [4:0] coef_addr;
    logic out_strobe, ready, busy, overrun;

    cic_comp_fir_decim #(.IN_WIDTH(W), .OUT_WIDTH(W), .COEF_WIDTH(W), .NTAPS(NT)) dut (
        .clock(clock), .reset(reset), .in_strobe(in_strobe), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_strobe(out_strobe), .out_data(out_data), .ready(ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {int due; longint y;} pend_t;
    pend_t  pend[$];
    longint hist[$];
    longint m_coef[NT];
    int     cyc = 0, since_rst = 0, t_last = 0;
    bit     m_phase = 0, have_last = 0, live = 0;
    bit     exp_strobe = 0, exp_busy = 0, exp_ready = 0, exp_overrun = 0;
    longint exp_out = 0;

    function automatic longint round_sat(input longint acc);
        longint r = (acc + 64'sd65536) >>> 17;
        if (r > 131071) return 131071;
        if (r < -131072) return -131072;
        return r;
    endfunction

    function automatic longint golden();
        longint acc = 0;
        for (int k = 0; k < NT && k < hist.size(); k++) acc += m_coef[k] * hist[hist.size() - 1 - k];
        return round_sat(acc);
    endfunction

    // Model: y[n] over the last NT accepted samples; a trigger is taken only if LAT+1 edges passed since the last.
    always @(posedge clock) begin
        cyc++;
        exp_strobe = 1'b0;
        if (coef_we) m_coef[coef_addr] = longint'($signed(coef_data));
        if (reset) begin
            live = 1'b1;
            since_rst = 0;
            m_phase = 1'b0;
            have_last = 1'b0;
            hist.delete();
            pend.delete();
            exp_out = 0;
            exp_overrun = 1'b0;
        end else begin
            since_rst++;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                exp_strobe = 1'b1;
                exp_out = pend[0].y;
                void'(pend.pop_front());
            end
            if (in_strobe && since_rst > NT) begin
                hist.push_back(longint'($signed(in_data)));
                if (hist.size() > NT) void'(hist.pop_front());
                if (m_phase) begin
                    if (have_last && cyc - t_last <= LAT) begin
                        exp_overrun = 1'b1;
                    end else begin
                        have_last = 1'b1;
                        t_last = cyc;
                        pend.push_back('{cyc + LAT, golden()});
                    end
                end
                m_phase = !m_phase;
            end
        end
        exp_busy  = !reset && have_last && (cyc - t_last < LAT);
        exp_ready = !reset && since_rst >= NT;
    end

    always @(negedge clock) begin
        if (live) begin
            check("out_strobe", longint'(out_strobe), longint'(exp_strobe));
            check("out_data", longint'($signed(out_data)), exp_out);
            check("busy", longint'(busy), longint'(exp_busy));
            check("ready", longint'(ready), longint'(exp_ready));
            check("overrun", longint'(overrun), longint'(exp_overrun));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_coef(input int k, input longint v);
        coef_we = 1'b1;
        coef_addr = 5'(k);
        coef_data = W'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic send(input longint x);
        in_data = W'(x);
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
    endtask

    task automatic run_pair(input longint a, input longint b, output longint y, output int lat);
        send(a);
        tick();
        send(b);
        lat = 0;
        while (lat < 60) begin
            tick();
            lat++;
            if (out_strobe) break;
        end
        y = longint'($signed(out_data));
    endtask

    task automatic pair_check(input string name, input longint a, input longint b, input longint exp);
        longint y;
        int lat;
        run_pair(a, b, y, lat);
        check(name, y, exp);
        check({name, "_latency"}, longint'(lat), longint'(LAT));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (n < 100 && !ready) begin
            tick();
            n++;
        end
        check("wait_ready", longint'(ready), 1);
    endtask

    initial begin
        longint y;
        int lat;
        int n;
        reset = 1'b1; in_strobe = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick();
        tick();
        check("rst_out_strobe", longint'(out_strobe), 0);
        check("rst_out_data", longint'($signed(out_data)), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_ready", longint'(ready), 0);
        check("rst_overrun", longint'(overrun), 0);

        for (int k = 0; k < NT; k++) write_coef(k, 4096);
        reset = 1'b0;
        n = 0;
        in_data = W'(12345);
        in_strobe = 1'b1;
        while (n < 100 && !ready) begin
            tick();
            n++;
        end
        in_strobe = 1'b0;
        check("ready_after_clear", longint'(n), 32);
        pair_check("clear_zero", 0, 0, 0);

        for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 65536 : (k == 1) ? 32768 : 0);
        pair_check("tap1_1000", 1000, 0, 250);
        pair_check("zero_pair", 0, 0, 0);
        pair_check("tap0_1000", 0, 1000, 500);

        for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 1 : 0);
        pair_check("rnd_pos_half", 0, 65536, 1);
        pair_check("rnd_pos_below", 0, 65535, 0);
        pair_check("rnd_neg_half", 0, -65536, 0);
        pair_check("rnd_neg_below", 0, -65537, -1);

        for (int k = 0; k < NT; k++) write_coef(k, 131071);
        for (int i = 0; i < 16; i++) pair_check("sat_pos", 131071, 131071, 131071);
        for (int i = 0; i < 15; i++) run_pair(-131072, -131072, y, lat);
        pair_check("sat_neg", -131072, -131072, -131072);

        for (int k = 0; k < NT; k++) write_coef(k, (k + 1) * 1000 - 16000);
        check("overrun_clear", longint'(overrun), 0);
        for (int i = 0; i < 100; i++) begin
            in_data = W'(((i * 7919) % 200000) - 100000);
            in_strobe = 1'b1;
            tick();
            in_strobe = 1'b0;
            tick();
        end
        check("overrun_set", longint'(overrun), 1);
        repeat (100) tick();
        check("overrun_sticky", longint'(overrun), 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("overrun_reset", longint'(overrun), 0);
        wait_ready();
        send(500);
        tick();
        send(-300);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("midrst_strobe", longint'(out_strobe), 0);
            check("midrst_busy", longint'(busy), 0);
            check("midrst_ready", longint'(ready), 0);
            tick();
        end
        check("midrst_ready_up", longint'(ready), 1);
        pair_check("after_midrst", 300, -700, 48);

        repeat (40) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
